// File: rtl/fft_pkg.sv
// fft_pkg -- definitions shared by the FFT front-end blocks.
//   DATA_W_DEF : default signed sample width
//   state_t    : delay-commutator phase (FILL = buffering the first half
//                of a frame, PAIR = emitting butterfly pairs)
//   idx_width  : ceil(log2(n)), never less than 1, for sizing counters
//                and index ports
package fft_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_t;

  // ceil(log2(n)), with a floor of one bit so an index port is never
  // zero width.
  function automatic int idx_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage : fft_pkg

// File: rtl/half_frame_buf.sv
// half_frame_buf -- holds the first half of an FFT frame until its partner
// samples arrive.
//   clk   : clock, writes on rising edge
//   we    : write enable
//   waddr : write address (0..DEPTH-1)
//   wdata : sample to store
//   raddr : read address (0..DEPTH-1)
//   rdata : sample at raddr, combinational (asynchronous read)
module half_frame_buf #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset. Every location is written during
  // FILL before PAIR can read it, so reset would only cost area and keep
  // the array out of RAM/LUT-RAM inference.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // DEPTH is a power of two equal to 2**ADDR_W, so raddr is always in range.
  assign rdata = mem[raddr];

endmodule : half_frame_buf

// File: rtl/delay_commutator.sv
// delay_commutator -- turns a serial stream x[0]..x[N-1] into radix-2
// butterfly operand pairs (x[k], x[k+N/2]) in ascending k.
//   clk       : clock, all state updates on rising edge
//   rst       : synchronous active-high reset
//   in_valid  : in_data carries a sample this cycle
//   in_data   : signed time-domain sample, frame order
//   out_valid : single-cycle pulse, out_a/out_b/out_index valid
//   out_a     : x[k]       (upper butterfly operand)
//   out_b     : x[k+N/2]   (lower butterfly operand)
//   out_index : twiddle index k
//   out_last  : pulse with the final pair of the frame (k = N/2-1)
// The first half of each frame is parked in half_frame_buf; each sample of
// the second half is paired with its buffered partner and registered out
// one cycle after it is accepted.
module delay_commutator
  import fft_pkg::*;
#(
  parameter int N      = 8,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_a,
  output logic signed [DATA_W-1:0] out_b,
  output logic [idx_width(N/2)-1:0] out_index,
  output logic                     out_last
);

  localparam int HALF  = N / 2;
  localparam int IDX_W = idx_width(HALF);
  localparam int CNT_W = idx_width(N);

  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(HALF - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              buf_we;
  logic [IDX_W-1:0]  half_addr;
  logic [DATA_W-1:0] buf_rdata;

  // A sample raised together with rst is not a real sample.
  assign accept = in_valid && !rst;

  // In FILL cnt < N/2, so its low bits are the write address directly. In
  // PAIR cnt >= N/2, and dropping the top bit is exactly cnt - N/2, the
  // partner's address and the twiddle index. One slice serves both.
  assign half_addr = cnt[IDX_W-1:0];
  assign buf_we    = accept && (state == FILL);

  half_frame_buf #(
    .DEPTH  (HALF),
    .DATA_W (DATA_W),
    .ADDR_W (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (half_addr),
    .wdata (in_data),
    .raddr (half_addr),
    .rdata (buf_rdata)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // sees pre-edge values of cnt/state, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_index <= '0;
    end else begin
      // Strobes default low; data outputs keep their last pair.
      out_valid <= 1'b0;
      out_last  <= 1'b0;

      if (in_valid) begin
        // cnt is exactly log2(N) bits, so N-1 wraps to 0 naturally.
        cnt <= cnt + CNT_W'(1);

        case (state)
          FILL: begin
            if (cnt == LAST_FILL) begin
              state <= PAIR;
            end
          end

          PAIR: begin
            // Sample 0 of the next frame is written on a later edge, so
            // overwriting address 0 cannot disturb the pair taken here.
            out_valid <= 1'b1;
            out_a     <= buf_rdata;
            out_b     <= in_data;
            out_index <= half_addr;
            out_last  <= (half_addr == LAST_IDX);
            if (cnt == LAST_PAIR) begin
              state <= FILL;
            end
          end

          default: state <= FILL;
        endcase
      end
    end
  end

endmodule : delay_commutator

// File: tb/tb_delay_commutator.sv
// tb_delay_commutator -- self-checking bench for delay_commutator (N=8).
// A frame-position model predicts the registered outputs each cycle; a
// negedge process compares them. Directed frames are also checked against
// hand-written pair lists, followed by a long randomized run with gaps and
// sporadic resets.
module tb_delay_commutator;

  localparam int N      = 8;
  localparam int DATA_W = 8;
  localparam int HALF   = N / 2;
  localparam int IDX_W  = 2;

  logic                     clk;
  logic                     rst;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_a;
  logic signed [DATA_W-1:0] out_b;
  logic [IDX_W-1:0]         out_index;
  logic                     out_last;

  int n_checks = 0;
  int n_errors = 0;

  delay_commutator #(
    .N      (N),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_index (out_index),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pos = position of the next sample within its frame. The first half of
  // a frame is remembered; each second-half sample yields a pair whose
  // values appear on the outputs after this edge.
  int                       pos;
  logic signed [DATA_W-1:0] half_mem [HALF];
  int                       e_valid, e_last, e_a, e_b, e_k;

  always @(posedge clk) begin
    if (rst) begin
      pos = 0; e_valid = 0; e_last = 0; e_a = 0; e_b = 0; e_k = 0;
    end else begin
      e_valid = 0;
      e_last  = 0;
      if (in_valid) begin
        if (pos < HALF) begin
          half_mem[pos] = in_data;
        end else begin
          e_a     = half_mem[pos - HALF];
          e_b     = in_data;
          e_k     = pos - HALF;
          e_valid = 1;
          e_last  = (e_k == HALF - 1) ? 1 : 0;
        end
        pos = (pos + 1) % N;
      end
    end
  end

  // ---------------- compare + log ----------------
  int log_a[$], log_b[$], log_k[$], log_l[$];

  always @(negedge clk) begin
    check("out_valid", out_valid, e_valid);
    check("out_last",  out_last,  e_last);
    check("out_a",     $signed(out_a), e_a);
    check("out_b",     $signed(out_b), e_b);
    check("out_index", out_index, e_k);
    if (out_valid === 1'b1) begin
      log_a.push_back($signed(out_a));
      log_b.push_back($signed(out_b));
      log_k.push_back(int'(out_index));
      log_l.push_back(int'(out_last));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input int d, input logic r);
    @(negedge clk);
    in_valid = v;
    in_data  = d[DATA_W-1:0];
    rst      = r;
  endtask

  task automatic feed(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) drive(1'b1, i, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
  endtask

  task automatic clear_log();
    log_a.delete(); log_b.delete(); log_k.delete(); log_l.delete();
  endtask

  // Compare the captured pairs with a hand-written expected list.
  task automatic check_log(input string tag, input int ea[$], input int eb[$],
                           input int ek[$]);
    int n;
    check({tag, " pair count"}, log_a.size(), ea.size());
    n = (log_a.size() < ea.size()) ? log_a.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " a"},    log_a[i], ea[i]);
      check({tag, " b"},    log_b[i], eb[i]);
      check({tag, " k"},    log_k[i], ek[i]);
      check({tag, " last"}, log_l[i], (ek[i] == HALF - 1) ? 1 : 0);
    end
    clear_log();
  endtask

  int qa[$], qb[$], qk[$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    drive(1'b0, 0, 1'b1);
    drive(1'b0, 0, 1'b1);
    // Reset values, literal.
    check("reset out_valid", out_valid, 0);
    check("reset out_last",  out_last,  0);
    check("reset out_a",     out_a,     0);
    check("reset out_b",     out_b,     0);
    check("reset out_index", out_index, 0);
    drive(1'b0, 0, 1'b0);
    clear_log();

    // Continuous frame 1..8.
    feed(1, 8); idle(2);
    qa = '{1, 2, 3, 4}; qb = '{5, 6, 7, 8}; qk = '{0, 1, 2, 3};
    check_log("cont", qa, qb, qk);

    // Gaps of 3 after samples 2 and 6.
    feed(1, 2); idle(3); feed(3, 6); idle(3); feed(7, 8); idle(2);
    check_log("gaps", qa, qb, qk);

    // Back-to-back frames.
    feed(1, 16); idle(2);
    qa = '{1, 2, 3, 4, 9, 10, 11, 12}; qb = '{5, 6, 7, 8, 13, 14, 15, 16};
    qk = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_log("b2b", qa, qb, qk);

    // Mid-frame reset, with in_valid high during reset (must be ignored).
    feed(1, 6);
    drive(1'b1, 99, 1'b1);
    feed(21, 28); idle(2);
    qa = '{1, 2, 21, 22, 23, 24}; qb = '{5, 6, 25, 26, 27, 28};
    qk = '{0, 1, 0, 1, 2, 3};
    check_log("reset", qa, qb, qk);

    // Signed extremes.
    drive(1'b1, -128, 1'b0); drive(1'b1, 127, 1'b0);
    drive(1'b1, -1, 1'b0);   drive(1'b1, 0, 1'b0);
    drive(1'b1, 127, 1'b0);  drive(1'b1, -128, 1'b0);
    drive(1'b1, 0, 1'b0);    drive(1'b1, -1, 1'b0);
    idle(2);
    qa = '{-128, 127, -1, 0}; qb = '{127, -128, 0, -1}; qk = '{0, 1, 2, 3};
    check_log("signed", qa, qb, qk);

    // Randomized stream: ~60% valid, rare resets (in_valid random during them).
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
            int'($urandom_range(0, 255)),
            ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_delay_commutator
